sme_host: RTL and testbench
===========================

# sme_host

Host-side driver for the string-matching engine: buffers one string (up to 32 chars) and one pattern (up to 8 chars) from an upstream loader, then replays them on the engine's `chardata`/`isstring`/`ispattern` input protocol. It waits for the engine's `valid` pulse, captures `match`/`match_index` and presents one result per job upstream, with a timeout guard. It sits between the test/control logic and the matching engine and is the transmitting and collecting end of that engine's interface.

## Interface
- `STR_MAX`, 32: string buffer depth in characters.
- `PAT_MAX`, 8: pattern buffer depth in characters.
- `TIMEOUT`, 255: maximum cycles to wait for `valid` (8-bit counter).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `str_clr` in 1: empty the string buffer and mark the string dirty.
- `str_we` in 1: append `str_wdata` to the string buffer.
- `str_wdata` in 8: string character.
- `pat_we` in 1: append `pat_wdata` to the pattern buffer.
- `pat_wdata` in 8: pattern character.
- `go` in 1: launch a job; single-cycle pulse.
- `busy` out 1: high from `go` acceptance until `res_valid`.
- `chardata` out 8: character to engine.
- `isstring` out 1: `chardata` is a string character.
- `ispattern` out 1: `chardata` is a pattern character.
- `valid` in 1: engine result strobe.
- `match` in 1: engine match flag.
- `match_index` in 5: engine match position.
- `res_valid` out 1: one-cycle result strobe.
- `res_match` out 1: captured match flag.
- `res_index` out 5: captured match index.
- `res_timeout` out 1: the job ended by timeout.
- `load_err` out 1: sticky; a write was dropped because a buffer was full or the block was busy. Cleared only by `reset`.

## Operation
- **Loading (IDLE only):**
  - `str_we` writes `str[str_len]`, increments `str_len` (6-bit) and sets `str_dirty`.
  - `pat_we` writes `pat[pat_len]` and increments `pat_len` (4-bit).
  - A write with its length already at MAX is dropped and sets `load_err`.
  - `str_clr`: `str_len`←0, `str_dirty`←1. If `str_clr` and `str_we` occur in the same cycle, the char goes to index 0 and `str_len`=1.
- **Writes while `busy`:** dropped; they set `load_err`.
- **FSM:** IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
  - IDLE→SEND_STR on `go` when `pat_len`≠0, `str_dirty`=1 and `str_len`≠0.
  - IDLE→SEND_PAT on `go` when `pat_len`≠0 and either `str_dirty`=0 or `str_len`=0 (string reuse: the engine retains the previous string).
  - `go` with `pat_len`=0 is ignored: no `busy`, no outputs.
  - SEND_STR: drives `str[k]` with `isstring`=1 for k=0..`str_len`-1, then goes to SEND_PAT.
  - SEND_PAT: drives `pat[k]` with `ispattern`=1 for k=0..`pat_len`-1, then goes to WAIT.
  - WAIT: `isstring`=`ispattern`=0 and `chardata`=0; the timer counts up each cycle.
    - `valid`=1: capture `match` and `match_index`, `res_timeout`←0, go to DONE.
    - Timer reaches TIMEOUT with no `valid`: `res_match`←0, `res_index`←0, `res_timeout`←1, go to DONE.
  - DONE (1 cycle): `res_valid`=1, `pat_len`←0, `str_dirty`←0, then IDLE. `str_len` and the string contents are kept.
- **`valid` outside WAIT:** ignored; the result registers do not change.
- **`isstring` and `ispattern`:** never high in the same cycle.
- **`str_len`=0 with `str_dirty`=1:** SEND_STR is skipped. `str_dirty` still clears in DONE.

## Timing
- All outputs are registered. Reset values:
  - `chardata`=0, `isstring`=0, `ispattern`=0
  - `busy`=0, `res_valid`=0, `res_match`=0, `res_index`=0, `res_timeout`=0, `load_err`=0
  - internal: `str_len`=0, `pat_len`=0, `str_dirty`=0, state=IDLE.
- `go` sampled at edge t:
  - `busy`=1 and the first character (`isstring` or `ispattern`) appear from t+1.
  - Characters are back-to-back, one per cycle, with no gaps between string and pattern.
- After the last pattern char, both strobes are 0 from the next cycle; this idle cycle is the engine's end-of-input marker.
- `valid` sampled at edge v: `res_valid`=1 during cycle v+1; `busy` falls at v+2.
- Minimum job length from `go` to `res_valid` is `str_len`+`pat_len`+2 cycles, plus the engine's latency.
- Timeout: `res_valid` asserts TIMEOUT+1 cycles after the first WAIT cycle.
- `reset` mid-job: outputs go to reset values immediately and asynchronously; any in-flight job is abandoned with no `res_valid`.

## Test plan
- **String then pattern:** load "hello world" (11 chars) and pattern "wor"; pulse `go`.
  - Expect `isstring` for 11 cycles with `chardata` 0x68…0x64, then `ispattern` for 3 cycles (0x77,0x6F,0x72).
  - Engine model returns `valid`, `match`=1, idx=6 → `res_valid` one cycle later with `res_match`=1, `res_index`=6, `res_timeout`=0.
- **String reuse:** after the first test, load pattern "^h" and pulse `go`.
  - Expect no `isstring`, 2 `ispattern` cycles (0x5E,0x68).
  - Model returns `match`=1, idx=0 → `res_index`=0.
- **Timeout:** pattern "x"; the model never asserts `valid`.
  - Expect `res_valid` with `res_timeout`=1 and `res_match`=0, 256 cycles after entry to WAIT.
- **Overflow and busy writes:**
  - 33 `str_we` → `str_len`=32, `load_err`=1.
  - `pat_we` during `busy` → dropped; `pat_len` stays 0 after DONE.
- **Ignored go and stray valid:**
  - `go` with an empty pattern → `busy` stays 0 and there is no output activity.
  - `valid` pulse in IDLE → `res_*` unchanged.
- **Reset mid-job:** assert `reset` during SEND_STR.
  - Strobes drop asynchronously.
  - A subsequent `go` with fresh buffers runs normally.

Source files
------------

// File: rtl/sme_host.sv
// Host driver for the string-matching engine: buffers a string and a pattern, replays them as one char per cycle, then collects a single result or times out.
// First char appears one cycle after go; loader writes are dropped (load_err) while busy or when a buffer is full.
module sme_host #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       str_clr,
    input  logic       str_we,
    input  logic [7:0] str_wdata,
    input  logic       pat_we,
    input  logic [7:0] pat_wdata,
    input  logic       go,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       load_err
);
    localparam int SW = $clog2(STR_MAX);
    localparam int PW = $clog2(PAT_MAX);
    localparam logic [SW:0] STR_FULL = (SW+1)'(STR_MAX);
    localparam logic [PW:0] PAT_FULL = (PW+1)'(PAT_MAX);
    localparam logic [7:0]  TMO      = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

    state_t      state;
    logic [7:0]  str_mem [STR_MAX];
    logic [7:0]  pat_mem [PAT_MAX];
    logic [SW:0] str_len;
    logic [PW:0] pat_len;
    logic        str_dirty;
    logic [SW:0] cnt;
    logic [7:0]  timer;

    logic          idle;
    logic          str_ok;
    logic          pat_ok;
    logic [SW-1:0] str_waddr;

    assign idle      = (state == IDLE);
    // A clear in the same cycle frees the slot, so a write alongside str_clr always lands at index 0.
    assign str_ok    = idle && str_we && (str_clr || (str_len != STR_FULL));
    assign pat_ok    = idle && pat_we && (pat_len != PAT_FULL);
    assign str_waddr = str_clr ? '0 : str_len[SW-1:0];

    // Buffer contents survive reset and jobs; only the lengths define what is valid.
    always_ff @(posedge clk) begin
        if (str_ok) begin
            str_mem[str_waddr] <= str_wdata;
        end
        if (pat_ok) begin
            pat_mem[pat_len[PW-1:0]] <= pat_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            str_len     <= '0;
            pat_len     <= '0;
            str_dirty   <= 1'b0;
            cnt         <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            chardata    <= 8'h00;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_timeout <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            res_valid <= 1'b0;

            if ((str_we && !str_ok) || (pat_we && !pat_ok)) begin
                load_err <= 1'b1;
            end

            if (idle) begin
                if (str_clr) begin
                    str_len   <= str_we ? (SW+1)'(1) : '0;
                    str_dirty <= 1'b1;
                end else if (str_ok) begin
                    str_len   <= str_len + 1'b1;
                    str_dirty <= 1'b1;
                end
                if (pat_ok) begin
                    pat_len <= pat_len + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (go && (pat_len != '0)) begin
                        busy <= 1'b1;
                        cnt  <= (SW+1)'(1);
                        // A clean string is already held by the engine, so only the pattern is resent.
                        if (str_dirty && (str_len != '0)) begin
                            state    <= SEND_STR;
                            chardata <= str_mem[0];
                            isstring <= 1'b1;
                        end else begin
                            state     <= SEND_PAT;
                            chardata  <= pat_mem[0];
                            ispattern <= 1'b1;
                        end
                    end
                end
                SEND_STR: begin
                    if (cnt == str_len) begin
                        state     <= SEND_PAT;
                        isstring  <= 1'b0;
                        ispattern <= 1'b1;
                        chardata  <= pat_mem[0];
                        cnt       <= (SW+1)'(1);
                    end else begin
                        chardata <= str_mem[cnt[SW-1:0]];
                        cnt      <= cnt + 1'b1;
                    end
                end
                SEND_PAT: begin
                    if (cnt == (SW+1)'(pat_len)) begin
                        // The strobe-free cycle that follows marks end of input for the engine.
                        state     <= WAIT;
                        ispattern <= 1'b0;
                        chardata  <= 8'h00;
                        timer     <= 8'h00;
                    end else begin
                        chardata <= pat_mem[cnt[PW-1:0]];
                        cnt      <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (valid) begin
                        state       <= DONE;
                        res_valid   <= 1'b1;
                        res_match   <= match;
                        res_index   <= match_index;
                        res_timeout <= 1'b0;
                        pat_len     <= '0;
                        str_dirty   <= 1'b0;
                    end else if (timer == TMO) begin
                        state       <= DONE;
                        res_valid   <= 1'b1;
                        res_match   <= 1'b0;
                        res_index   <= 5'd0;
                        res_timeout <= 1'b1;
                        pat_len     <= '0;
                        str_dirty   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_host.sv
// Bench for sme_host: stimulus queues expected chars/results, a negedge monitor pops and compares.
module tb_sme_host;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       str_clr = 1'b0;
    logic       str_we = 1'b0;
    logic [7:0] str_wdata = 8'h00;
    logic       pat_we = 1'b0;
    logic [7:0] pat_wdata = 8'h00;
    logic       go = 1'b0;
    logic       busy;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid = 1'b0;
    logic       match = 1'b0;
    logic [4:0] match_index = 5'd0;
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic       load_err;

    always #5 clk = ~clk;

    sme_host dut (
        .clk(clk), .reset(reset), .str_clr(str_clr), .str_we(str_we), .str_wdata(str_wdata),
        .pat_we(pat_we), .pat_wdata(pat_wdata), .go(go), .busy(busy), .chardata(chardata),
        .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
        .match_index(match_index), .res_valid(res_valid), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .load_err(load_err)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] dat;
    } chr_t;

    typedef struct {
        logic       m;
        logic [4:0] idx;
        logic       tmo;
        int         lat;
    } res_t;

    chr_t exp_chr[$];
    res_t exp_res[$];
    chr_t ec;
    res_t er;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   wait_start = 0;
    int   n_wait = 0;
    int   n_res = 0;
    logic prev_pat = 1'b0;
    logic chk_busy_drop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every strobed char and every result is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (chk_busy_drop) begin
            check("busy_fall", int'(busy), 0);
            chk_busy_drop = 1'b0;
        end
        if (isstring || ispattern) begin
            if (exp_chr.size() == 0) begin
                check("unexpected_char", int'({isstring, ispattern, chardata}), 0);
            end else begin
                ec = exp_chr.pop_front();
                check("char_kind", int'({isstring, ispattern}), int'(ec.kind));
                check("chardata", int'(chardata), int'(ec.dat));
                check("busy_during_send", int'(busy), 1);
            end
        end
        if (prev_pat && !isstring && !ispattern) begin
            wait_start = cyc;
            n_wait++;
            check("wait_chardata", int'(chardata), 0);
        end
        prev_pat = ispattern;
        if (res_valid) begin
            if (exp_res.size() == 0) begin
                check("unexpected_res", int'(res_valid), 0);
            end else begin
                er = exp_res.pop_front();
                check("res_match", int'(res_match), int'(er.m));
                check("res_index", int'(res_index), int'(er.idx));
                check("res_timeout", int'(res_timeout), int'(er.tmo));
                check("res_latency", cyc - wait_start, er.lat);
                check("busy_at_res", int'(busy), 1);
                chk_busy_drop = 1'b1;
            end
            n_res++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic put_str(input logic [7:0] c, input logic clr);
        str_we = 1'b1; str_clr = clr; str_wdata = c;
        tick();
        str_we = 1'b0; str_clr = 1'b0;
    endtask

    task automatic put_pat(input logic [7:0] c);
        pat_we = 1'b1; pat_wdata = c;
        tick();
        pat_we = 1'b0;
    endtask

    task automatic load_str(input string s, input bit push);
        for (int i = 0; i < s.len(); i++) begin
            put_str(s[i], 1'b0);
            if (push) exp_chr.push_back({2'b10, s[i]});
        end
    endtask

    task automatic load_pat(input string s, input bit push);
        for (int i = 0; i < s.len(); i++) begin
            put_pat(s[i]);
            if (push) exp_chr.push_back({2'b01, s[i]});
        end
    endtask

    task automatic run_job(input bit respond, input int d, input logic m, input logic [4:0] idx, input bit poke);
        int   w0;
        int   r0;
        int   k;
        res_t r;
        w0 = n_wait;
        r0 = n_res;
        r.m   = respond ? m : 1'b0;
        r.idx = respond ? idx : 5'd0;
        r.tmo = !respond;
        r.lat = respond ? d + 1 : 256;
        exp_res.push_back(r);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_after_go", int'(busy), 1);
        check("first_char_after_go", int'(isstring | ispattern), 1);
        if (poke) put_pat(8'h55);
        k = 0;
        while (n_wait == w0 && k < 100) begin
            tick();
            k++;
        end
        check("reach_wait", n_wait - w0, 1);
        if (respond) begin
            repeat (d) tick();
            valid = 1'b1; match = m; match_index = idx;
            tick();
            valid = 1'b0; match = 1'b0; match_index = 5'd0;
        end
        k = 0;
        while (n_res == r0 && k < 400) begin
            tick();
            k++;
        end
        check("result_seen", n_res - r0, 1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_strobes", int'({isstring, ispattern}), 0);
        check("rst_chardata", int'(chardata), 0);
        check("rst_res", int'({res_valid, res_match, res_index, res_timeout}), 0);
        check("rst_load_err", int'(load_err), 0);

        // String then pattern: "hello world" / "wor", match at 6.
        load_str("hello world", 1'b1);
        load_pat("wor", 1'b1);
        run_job(1'b1, 3, 1'b1, 5'd6, 1'b0);

        // String reuse: only the pattern is resent.
        load_pat("^h", 1'b1);
        run_job(1'b1, 0, 1'b1, 5'd0, 1'b0);
        check("no_err_yet", int'(load_err), 0);

        // Timeout, with a pattern write attempted while busy.
        load_pat("x", 1'b1);
        run_job(1'b0, 0, 1'b0, 5'd0, 1'b1);
        check("busy_write_err", int'(load_err), 1);

        // go with an empty pattern (the busy-time write must not have landed).
        go = 1'b1;
        tick();
        go = 1'b0;
        check("ignored_go_busy", int'(busy), 0);
        repeat (3) tick();
        check("ignored_go_busy_later", int'(busy), 0);

        // Stray valid in IDLE leaves results untouched.
        valid = 1'b1; match = 1'b1; match_index = 5'd17;
        tick();
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        tick();
        check("stray_res_match", int'(res_match), 0);
        check("stray_res_index", int'(res_index), 0);
        check("stray_res_timeout", int'(res_timeout), 1);

        // Reset during SEND_STR.
        put_str("a", 1'b1);
        load_str("bcdef", 1'b0);
        load_pat("b", 1'b0);
        exp_chr.push_back({2'b10, 8'h61});
        exp_chr.push_back({2'b10, 8'h62});
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_isstring", int'(isstring), 0);
        check("arst_chardata", int'(chardata), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_load_err", int'(load_err), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("arst_queue_empty", exp_chr.size(), 0);

        // Fresh job after reset.
        load_str("ab", 1'b1);
        load_pat("b", 1'b1);
        run_job(1'b1, 2, 1'b1, 5'd1, 1'b0);
        check("fresh_no_err", int'(load_err), 0);

        // Overflow: clear+write together, 33 string writes and 9 pattern writes.
        for (int i = 0; i < 33; i++) begin
            put_str(8'h41 + 8'(i), i == 0);
            if (i < 32) exp_chr.push_back({2'b10, 8'h41 + 8'(i)});
            if (i == 31) check("str_full_no_err", int'(load_err), 0);
        end
        check("str_overflow_err", int'(load_err), 1);
        for (int i = 0; i < 9; i++) begin
            put_pat(8'h61 + 8'(i));
            if (i < 8) exp_chr.push_back({2'b01, 8'h61 + 8'(i)});
        end
        run_job(1'b1, 5, 1'b0, 5'd19, 1'b0);

        check("final_chr_queue", exp_chr.size(), 0);
        check("final_res_queue", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
